switch_led_ctrl: RTL

Parametrised switch-to-LED controller for the Basys3 labs. Each of N slide switches is synchronised, debounced and then mapped to its LED through a run-time selectable mode: direct, toggle-latch, blink or inverted. It sits directly between the board `sw` pins and the `led` pins. It generalises the plain wire-through lab with clocked, glitch-free behaviour.

---
 rtl/switch_led_if.sv | 29 ++
 rtl/switch_led_ctrl.sv | 128 ++++++++++++
 2 files changed

// File: rtl/switch_led_if.sv
// switch_led_if: board-side signal bundle for switch_led_ctrl.
// The master side drives raw switches and the global LED mode; the slave
// side (the controller) returns the LED drive, the debounced levels and the
// rising-edge pulses.
interface switch_led_if #(
   parameter int N = 16
);
   logic [N-1:0] sw;
   logic [1:0]   mode;
   logic [N-1:0] led;
   logic [N-1:0] sw_db;
   logic [N-1:0] sw_rise;

   modport master (
      output sw,
      output mode,
      input  led,
      input  sw_db,
      input  sw_rise
   );

   modport slave (
      input  sw,
      input  mode,
      output led,
      output sw_db,
      output sw_rise
   );
endinterface

// File: rtl/switch_led_ctrl.sv
// switch_led_ctrl: N-channel switch-to-LED controller.
// Each raw switch passes through a two-flop synchroniser and a
// consecutive-cycle debouncer; its debounced level drives its LED in one of
// four global modes: 0 direct, 1 toggle-latch, 2 blink, 3 invert.
// Optional feature macro: SWITCH_LED_BLINK_EN. When it is defined, the shared
// blink counter and phase exist and mode 2 blinks; when it is undefined,
// mode 2 is identical to mode 0.
module switch_led_ctrl #(
   parameter int N               = 16,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int BLINK_DIV       = 25000000
) (
   input logic       clk,
   input logic       rst_n,
   switch_led_if.slave bus
);

   localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [N-1:0]     sync1;
   logic [N-1:0]     sync2;
   logic [N-1:0]     sw_db_r;
   logic [N-1:0]     sw_db_d;
   logic [N-1:0]     sw_rise_r;
   logic [N-1:0]     latch;
   logic [N-1:0]     led_r;
   logic [N-1:0]     blink_mask;
   logic [CNT_W-1:0] cnt [N];

   // Next LED value for the selected mode; blink gating arrives as a mask.
   function automatic logic [N-1:0] led_next(input logic [1:0]   m,
                                             input logic [N-1:0] db,
                                             input logic [N-1:0] lat,
                                             input logic [N-1:0] mask);
      case (m)
         2'd0:    return db;
         2'd1:    return lat;
         2'd2:    return db & mask;
         default: return ~db;
      endcase
   endfunction

   // Two-flop synchroniser for the asynchronous switch pins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= bus.sw;
         sync2 <= sync1;
      end
   end

   // Debouncer: accept a new level only after it persists; any return to the
   // stable level restarts the count from zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sw_db_r <= '0;
         for (int i = 0; i < N; i++) cnt[i] <= '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (sync2[i] == sw_db_r[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_LAST) begin
               sw_db_r[i] <= sync2[i];
               cnt[i]     <= '0;
            end else begin
               cnt[i] <= cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   // Rising-edge pulse on the debounced level, and the toggle latch that
   // flips as that pulse ends (in every mode, so state survives mode changes).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sw_db_d   <= '0;
         sw_rise_r <= '0;
         latch     <= '0;
      end else begin
         sw_db_d   <= sw_db_r;
         sw_rise_r <= sw_db_r & ~sw_db_d;
         latch     <= latch ^ sw_rise_r;
      end
   end

`ifdef SWITCH_LED_BLINK_EN
   localparam int              BLK_W    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

   logic [BLK_W-1:0] blk_cnt;
   logic             phase;

   // Free-running blink divider; phase flips once per half-period.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blk_cnt <= '0;
         phase   <= 1'b0;
      end else if (blk_cnt == BLK_LAST) begin
         blk_cnt <= '0;
         phase   <= ~phase;
      end else begin
         blk_cnt <= blk_cnt + BLK_W'(1);
      end
   end

   assign blink_mask = {N{phase}};
`else
   // Blink hardware compiled out: mode 2 passes the debounced level through.
   assign blink_mask = {N{(BLINK_DIV >= 1)}};
`endif

   // Registered LED drive; a mode change shows on the next edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         led_r <= '0;
      end else begin
         led_r <= led_next(bus.mode, sw_db_r, latch, blink_mask);
      end
   end

   assign bus.led     = led_r;
   assign bus.sw_db   = sw_db_r;
   assign bus.sw_rise = sw_rise_r;

endmodule
